token_inject_arbiter: RTL

//  Shares the single DDP token-injection port (send/ack, 62-bit token) among N_REQ

---
 rtl/tia_pkg.sv | 30 +++
 rtl/token_inject_arbiter_rr_pick.sv | 30 +++
 rtl/token_inject_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tia_pkg.sv
// Shared definitions for token_inject_arbiter: FSM state encoding, default
// token width, DDP token field offsets and the round-robin pointer helper.
package tia_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } tia_state_t;

    localparam int TOKEN_W_DEF = 62;

    // Token layout {lr, uni_opr, mem_wen[1:0], node[13:0], gen[11:0], opr[31:0]}
    localparam int TOK_OPR_LSB     = 0;
    localparam int TOK_OPR_W       = 32;
    localparam int TOK_GEN_LSB     = 32;
    localparam int TOK_GEN_W       = 12;
    localparam int TOK_NODE_LSB    = 44;
    localparam int TOK_NODE_W      = 14;
    localparam int TOK_MEMWEN_LSB  = 58;
    localparam int TOK_MEMWEN_W    = 2;
    localparam int TOK_UNIOPR_BIT  = 60;
    localparam int TOK_LR_BIT      = 61;

    // Next round-robin start position after serving requester idx.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/token_inject_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set bit of
// cand_i at or after ptr_i (wrapping N_REQ-1 -> 0) as one-hot plus index.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] cand_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan offsets from farthest to nearest so the nearest candidate wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            automatic int k = (int'(ptr_i) + i) % N_REQ;
            if (cand_i[k]) begin
                grant_o    = '0;
                grant_o[k] = 1'b1;
                idx_o      = PTR_W'(k);
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/token_inject_arbiter.sv
// token_inject_arbiter: round-robin sharing of the single DDP token-injection
// port among N_REQ 4-phase requesters. ack_i is asynchronous and passes
// through a SYNC_STAGES flop chain before any FSM decision.
// Optional feature: define INJ_STAT_EN to add per-requester completed-token
// counters on count_o; otherwise count_o is tied to zero.
module token_inject_arbiter
    import tia_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TOKEN_W     = TOKEN_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         mask_i,
    input  logic [N_REQ-1:0]         send_i,
    input  logic [N_REQ*TOKEN_W-1:0] token_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     send_o,
    output logic [TOKEN_W-1:0]       token_o,
    input  logic                     ack_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic [N_REQ*CNT_W-1:0]   count_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    tia_state_t               r_state;
    logic [SYNC_STAGES-1:0]   r_ack_sync;
    logic [PTR_W-1:0]         r_rr_ptr;
    logic [PTR_W-1:0]         r_owner;
    logic                     r_send;
    logic [N_REQ-1:0]         r_ack;
    logic [N_REQ-1:0]         r_grant;
    logic                     r_busy;
    logic [TOKEN_W-1:0]       r_token;

    logic                     w_ack_s;
    logic [N_REQ-1:0]         w_cand;
    logic [N_REQ-1:0]         w_pick;
    logic [PTR_W-1:0]         w_pick_idx;
    logic                     w_pick_valid;
    logic [TOKEN_W-1:0]       w_pick_token;
    logic                     w_release_done;

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // Requesters still holding an ack are not eligible, and nobody is granted
    // while ack_s is high so SEND always sees a fresh rising edge.
    assign w_cand = send_i & mask_i & ~r_ack & {N_REQ{~w_ack_s}};

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .cand_i  (w_cand),
        .ptr_i   (r_rr_ptr),
        .grant_o (w_pick),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

    assign w_pick_token   = token_i[int'(w_pick_idx)*TOKEN_W +: TOKEN_W];
    assign w_release_done = (r_state == ST_RELEASE) && !w_ack_s && !send_i[r_owner];

    // ack_i synchroniser chain into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    // Arbitration / handshake FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_send   <= 1'b0;
            r_ack    <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_token  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_token <= w_pick_token;
                        r_grant <= w_pick;
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // send_o comes up one cycle after the grant and holds
                    // until the synchronised ack arrives.
                    if (w_ack_s) begin
                        r_send         <= 1'b0;
                        r_ack[r_owner] <= 1'b1;
                        r_state        <= ST_RELEASE;
                    end else begin
                        r_send <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (w_release_done) begin
                        r_ack    <= '0;
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= PTR_W'(rr_next(int'(r_owner), N_REQ));
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign send_o  = r_send;
    assign ack_o   = r_ack;
    assign grant_o = r_grant;
    assign busy_o  = r_busy;
    assign token_o = r_token;

`ifdef INJ_STAT_EN
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_count;

            // Count one completed token when this requester's transfer retires.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (w_release_done && (int'(r_owner) == gi)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign count_o[gi*CNT_W +: CNT_W] = r_count;
        end
    endgenerate
`else
    assign count_o = '0;
`endif

endmodule
